psr_bank: RTL

Banked program status register block for the pipelined ARM-subset CPU. It replaces the single 32-bit CPSR flop with a parametrised CPSR plus one SPSR per privileged mode, and adds mode switching, interrupt-mask bits, MSR field writes, exception entry with a request/acknowledge handshake, and exception return. It sits beside the register file; the execute stage drives flag updates and the control unit drives exception entry and return.

---
 rtl/psr_bank_pkg.sv | 45 ++++
 rtl/psr_field_merge.sv | 34 +++
 rtl/psr_bank.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/psr_bank_pkg.sv
// Shared constants, state encoding and mode helpers for the banked program status registers.
package psr_bank_pkg;

  localparam int FULLW       = 32;
  localparam int FLAGS_W     = 4;
  localparam int FLAGS_START = FULLW - FLAGS_W;
  localparam int MODE_W      = 5;
  localparam int NUM_SPSR    = 3;
  localparam int BANK_W      = 2;
  localparam int NUM_BYTES   = 4;
  localparam int I_BIT       = 7;
  localparam int F_BIT       = 6;

  localparam logic [MODE_W-1:0] MODE_USR = 5'b10000;
  localparam logic [MODE_W-1:0] MODE_FIQ = 5'b10001;
  localparam logic [MODE_W-1:0] MODE_IRQ = 5'b10010;
  localparam logic [MODE_W-1:0] MODE_SVC = 5'b10011;

  localparam logic [FULLW-1:0] CPSR_RESET = 32'h0000_00D3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } psr_state_e;

  function automatic logic is_legal_mode(input logic [MODE_W-1:0] m);
    return (m == MODE_USR) || (m == MODE_FIQ) || (m == MODE_IRQ) || (m == MODE_SVC);
  endfunction

  function automatic logic has_bank(input logic [MODE_W-1:0] m);
    return (m == MODE_FIQ) || (m == MODE_IRQ) || (m == MODE_SVC);
  endfunction

  // Callers gate the result with has_bank; unbanked modes fall through to the SVC slot.
  function automatic logic [BANK_W-1:0] mode_to_bank(input logic [MODE_W-1:0] m);
    logic [BANK_W-1:0] b;
    case (m)
      MODE_FIQ: b = 2'd0;
      MODE_IRQ: b = 2'd1;
      default:  b = 2'd2;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/psr_field_merge.sv
// Combinational merge of a status word: MSR byte fields, USR-mode protection and per-flag writes.
module psr_field_merge
  import psr_bank_pkg::*;
(
  input  logic [FULLW-1:0]     cur,
  input  logic [NUM_BYTES-1:0] byte_en,
  input  logic [FULLW-1:0]     byte_wd,
  input  logic                 usr_protect,
  input  logic [FLAGS_W-1:0]   flag_en,
  input  logic [FLAGS_W-1:0]   flag_wd,
  output logic [FULLW-1:0]     merged,
  output logic                 bad_mode
);

  logic [NUM_BYTES-1:0] eff_en;

  // An illegal mode in byte 0 keeps the old mode field but lets I, F and T bits through.
  always_comb begin
    eff_en   = usr_protect ? (byte_en & 4'b1000) : byte_en;
    merged   = cur;
    bad_mode = 1'b0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (eff_en[i]) merged[8*i +: 8] = byte_wd[8*i +: 8];
    end
    if (eff_en[0] && !is_legal_mode(byte_wd[MODE_W-1:0])) begin
      merged[MODE_W-1:0] = cur[MODE_W-1:0];
      bad_mode           = 1'b1;
    end
    for (int k = 0; k < FLAGS_W; k++) begin
      if (flag_en[k]) merged[FLAGS_START+k] = flag_wd[k];
    end
  end

endmodule

// File: rtl/psr_bank.sv
// CPSR plus one SPSR per privileged mode, with exception entry/ack handshake, eret and MSR writes.
module psr_bank
  import psr_bank_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [FLAGS_W-1:0]   flag_we,
  input  logic [FLAGS_W-1:0]   flag_wd,
  input  logic                 msr_we,
  input  logic                 msr_spsr,
  input  logic [NUM_BYTES-1:0] msr_mask,
  input  logic [FULLW-1:0]     msr_wd,
  input  logic                 exc_req,
  input  logic [MODE_W-1:0]    exc_mode,
  output logic                 exc_ack,
  input  logic                 eret,
  output logic [FULLW-1:0]     cpsr_out,
  output logic [FULLW-1:0]     spsr_out,
  output logic [MODE_W-1:0]    mode_out,
  output logic                 bad_mode
);

  psr_state_e state, state_nxt;

  logic [FULLW-1:0]     cpsr, cpsr_nxt;
  logic [FULLW-1:0]     spsr [NUM_SPSR];
  logic [MODE_W-1:0]    cur_mode;
  logic                 cur_banked;
  logic [BANK_W-1:0]    cur_bank;
  logic [FULLW-1:0]     cur_spsr;
  logic                 take_exc;
  logic                 spsr_we;
  logic [BANK_W-1:0]    spsr_idx;
  logic [FULLW-1:0]     spsr_wd;
  logic                 bad_set;
  logic [NUM_BYTES-1:0] cpsr_byte_en;
  logic [FLAGS_W-1:0]   cpsr_flag_en;
  logic [FULLW-1:0]     cpsr_merged, spsr_merged;
  logic                 cpsr_merge_bad, spsr_merge_bad;

  assign cur_mode   = cpsr[MODE_W-1:0];
  assign cur_banked = has_bank(cur_mode);
  assign cur_bank   = mode_to_bank(cur_mode);
  assign cur_spsr   = cur_banked ? spsr[cur_bank] : '0;
  assign take_exc   = (state == ST_IDLE) && exc_req && !stall;

  assign cpsr_out = cpsr;
  assign spsr_out = cur_spsr;
  assign mode_out = cur_mode;
  assign exc_ack  = (state == ST_ACK);

  assign cpsr_byte_en = (msr_we && !msr_spsr) ? msr_mask : '0;
  assign cpsr_flag_en = msr_we ? '0 : flag_we;

  psr_field_merge u_cpsr_merge (
    .cur         (cpsr),
    .byte_en     (cpsr_byte_en),
    .byte_wd     (msr_wd),
    .usr_protect (cur_mode == MODE_USR),
    .flag_en     (cpsr_flag_en),
    .flag_wd     (flag_wd),
    .merged      (cpsr_merged),
    .bad_mode    (cpsr_merge_bad)
  );

  psr_field_merge u_spsr_merge (
    .cur         (cur_spsr),
    .byte_en     (msr_mask),
    .byte_wd     (msr_wd),
    .usr_protect (1'b0),
    .flag_en     ('0),
    .flag_wd     ('0),
    .merged      (spsr_merged),
    .bad_mode    (spsr_merge_bad)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // The ACK state always lasts exactly one cycle, even under stall.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (take_exc) state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // One winner per cycle: exception entry, then eret, then MSR, then flag writes.
  always_comb begin
    cpsr_nxt = cpsr;
    spsr_we  = 1'b0;
    spsr_idx = cur_bank;
    spsr_wd  = spsr_merged;
    bad_set  = 1'b0;
    if (stall) begin
      cpsr_nxt = cpsr;
    end else if (take_exc) begin
      if (has_bank(exc_mode)) begin
        spsr_we  = 1'b1;
        spsr_idx = mode_to_bank(exc_mode);
        spsr_wd  = cpsr;
      end
      if (is_legal_mode(exc_mode)) cpsr_nxt[MODE_W-1:0] = exc_mode;
      else                         bad_set = 1'b1;
      cpsr_nxt[I_BIT] = 1'b1;
      if (exc_mode == MODE_FIQ) cpsr_nxt[F_BIT] = 1'b1;
    end else if (eret) begin
      if (!cur_banked) begin
        bad_set = 1'b1;
      end else begin
        cpsr_nxt = cur_spsr;
        if (!is_legal_mode(cur_spsr[MODE_W-1:0])) begin
          cpsr_nxt[MODE_W-1:0] = cur_mode;
          bad_set              = 1'b1;
        end
      end
    end else if (msr_we) begin
      if (msr_spsr) begin
        if (!cur_banked) begin
          bad_set = 1'b1;
        end else begin
          spsr_we = 1'b1;
          bad_set = spsr_merge_bad;
        end
      end else begin
        cpsr_nxt = cpsr_merged;
        bad_set  = cpsr_merge_bad;
      end
    end else if (|flag_we) begin
      cpsr_nxt = cpsr_merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpsr     <= CPSR_RESET;
      bad_mode <= 1'b0;
      for (int b = 0; b < NUM_SPSR; b++) spsr[b] <= '0;
    end else begin
      cpsr <= cpsr_nxt;
      if (bad_set) bad_mode <= 1'b1;
      if (spsr_we) spsr[spsr_idx] <= spsr_wd;
    end
  end

endmodule
